// File: rtl/core_pkg.sv
// Shared types and constants for the fetch stage of the pipelined RISC-V core.
package core_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST   = 32'h00000013;
    localparam logic [ILEN-1:0] ECALL_INST = 32'h00000073;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHalt
    } fetch_state_t;

    typedef enum logic [1:0] {
        PcHold,
        PcInc,
        PcRedirect
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with +4 / redirect / hold next-PC mux and fetch legality check.
module fetch_pc_gen
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     MEM_BYTES = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  pc_sel_t         pc_sel,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            pc_legal
);

    localparam int unsigned EndW = XLEN + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [EndW-1:0] pc_end;

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PcInc:      pc_d = pc_q + 64'd4;
            PcRedirect: pc_d = redirect_pc;
            default:    pc_d = pc_q;
        endcase
    end

    // One extra bit so a PC near the top of the address space cannot wrap into range.
    assign pc_end   = {1'b0, pc_q} + EndW'(4);
    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_end <= EndW'(MEM_BYTES));
    assign pc       = pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: sequences Instruction_Memory, registers words into a valid/ready
// IF/ID output, and handles stalls, redirects, ecall drain and illegal-fetch halt.
module inst_fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter int unsigned     MEM_BYTES = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [XLEN-1:0] Inst_Address,
    input  logic [ILEN-1:0] Instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_inst,
    output logic            halted,
    output logic            fetch_fault
);

    fetch_state_t    state_q, state_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic            fault_q, fault_d;

    pc_sel_t         pc_sel;
    logic [XLEN-1:0] pc;
    logic            pc_legal;
    logic            xfer;
    logic            out_free;

    fetch_pc_gen #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) u_pc_gen (
        .clk         (clk),
        .reset       (reset),
        .pc_sel      (pc_sel),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_legal    (pc_legal)
    );

    assign xfer     = valid_q && id_ready;
    assign out_free = !valid_q || id_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        pc_sel  = PcHold;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_sel  = PcRedirect;
                end else if (!pc_legal) begin
                    // An older, still-unconsumed word stays visible until decode takes it.
                    state_d = StHalt;
                    fault_d = 1'b1;
                    if (out_free) valid_d = 1'b0;
                end else if (out_free) begin
                    valid_d = 1'b1;
                    ipc_d   = pc;
                    inst_d  = Instruction;
                    if (Instruction == ECALL_INST) state_d = StDrain;
                    else                           pc_sel  = PcInc;
                end
            end
            StDrain: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_sel  = PcRedirect;
                    state_d = StRun;
                end else if (xfer) begin
                    valid_d = 1'b0;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (xfer) valid_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            ipc_q   <= '0;
            inst_q  <= NOP_INST;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    assign Inst_Address = pc;
    assign if_valid     = valid_q;
    assign if_pc        = ipc_q;
    assign if_inst      = inst_q;
    assign halted       = (state_q == StHalt);
    assign fetch_fault  = fault_q;

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch-stage controller that sequences the byte-addressed, combinational `Instruction_Memory` for the pipelined RISC-V core. It owns the program counter and drives `Inst_Address`. It registers each fetched word with its PC into a valid/ready IF/ID output, handles stalls and branch/jump redirects, and halts cleanly on `ecall` or an out-of-range/misaligned fetch.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `MEM_BYTES`, default 256: instruction memory size in bytes. A fetch is legal only if `pc[1:0]==0` and `pc+4 <= MEM_BYTES`.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE and begin fetching.
- `Inst_Address` out 64: address to `Instruction_Memory`, equal to the PC register (combinational).
- `Instruction` in 32: word returned by `Instruction_Memory`, same cycle.
- `redirect_valid` in 1: taken branch/jump from EX.
- `redirect_pc` in 64: redirect target.
- `id_ready` in 1: decode accepts the output this cycle.
- `if_valid` out 1: output holds a fetched instruction.
- `if_pc` out 64: PC of `if_inst`.
- `if_inst` out 32: fetched instruction.
- `halted` out 1: controller in HALT.
- `fetch_fault` out 1: sticky; HALT was entered due to an illegal fetch address.

## Operation
- **States:** IDLE, RUN, DRAIN, HALT.
- **IDLE:** no fetch, `if_valid`=0. `start`=1 moves to RUN next edge.
- **RUN, output free** (`!if_valid || id_ready`) and PC legal:
  - capture `if_inst<=Instruction`, `if_pc<=pc`, `if_valid<=1`;
  - `pc<=pc+4`, 64-bit wrapping add.
- **RUN, stall** (`if_valid && !id_ready`): pc, `if_*` and `Inst_Address` all hold.
- **Ecall:** if the captured word is 32'h00000073, the capture happens normally and the state moves to DRAIN. The PC does not advance.
- **DRAIN:**
  - When the ecall is consumed (`id_ready` with `if_valid`), clear `if_valid` and go to HALT.
  - No further fetches occur in DRAIN.
- **Illegal PC in RUN** (misaligned or `pc+4 > MEM_BYTES`):
  - no capture;
  - if the output is free, `if_valid<=0`;
  - go to HALT with `fetch_fault<=1`. A still-valid older output is held until consumed, then `if_valid` drops.
- **Redirect** has highest priority in RUN and DRAIN:
  - squash the output (`if_valid<=0`) regardless of `id_ready`;
  - `pc<=redirect_pc`; the state becomes RUN;
  - the target is fetched on the next cycle and its legality is checked then.
- **Redirect is ignored** in IDLE and HALT.
- **HALT:** `halted`=1; exited only by reset. `start` is ignored.
- **Reset mid-operation:** all state is discarded immediately (asynchronous). In-flight output is lost.

## Timing
- **Reset values:**
  - state IDLE, `pc`=RESET_PC, `Inst_Address`=RESET_PC;
  - `if_valid`=0, `if_pc`=0, `if_inst`=32'h00000013 (nop);
  - `halted`=0, `fetch_fault`=0.
- **Start latency:** `start` sampled at edge N puts the state in RUN at N. The first capture is at edge N+1, with `if_valid`=1 after it.
- **Throughput:** one instruction per cycle while `id_ready`=1 and no redirect.
- **Redirect latency:** `redirect_valid` at edge N leaves `if_valid`=0 after N. The target instruction is valid after N+1: one bubble.
- **Handshake:** a transfer occurs on an edge with `if_valid && id_ready`. While `if_valid && !id_ready` (no redirect), `if_pc`/`if_inst` are stable.
- **Simultaneous redirect + transfer:** the transfer completes (decode took the word), the new word is squashed, and the PC is redirected.
- **Simultaneous redirect + illegal PC:** redirect wins and no fault is raised.
- **`halted`** rises on the edge entering HALT. **`fetch_fault`** rises on the edge detecting the illegal PC.

## Structure
- **Shared package `core_pkg`:**
  - state enum `fetch_state_t`;
  - `NOP_INST`=32'h00000013 and `ECALL_INST`=32'h00000073;
  - `XLEN`=64 and `ILEN`=32.
- **Sub-module:** one natural sub-module, `fetch_pc_gen`, which holds the PC register and next-PC mux (+4 / redirect / hold) and produces the legality flag.
- **Top:** `inst_fetch_ctrl` holds the FSM and output register.
- **Memory:** `Instruction_Memory` is instantiated beside this block, not inside it.

## Test plan
- **Sequential fetch:** reset, `start`=1, `id_ready`=1, memory holds 10000513, 00500293, 00000b13 at 0/4/8.
  - Expect `if_pc`=0,4,8 on consecutive cycles with matching `if_inst`, and `if_valid` continuously 1 from cycle 2.
- **Stall:** drop `id_ready` for 3 cycles while `if_pc`=4.
  - Expect `if_pc`=4 and `if_inst`=00500293 held and `Inst_Address`=8 held.
  - After release, 8 follows the next cycle.
- **Redirect:** `redirect_valid`=1, `redirect_pc`=0x18 while `if_pc`=0x10 and `id_ready`=0.
  - Expect `if_valid`=0 for one cycle, then `if_pc`=0x18 with `if_inst`=045b0463.
- **Ecall halt:** place 00000073 at 0x0C.
  - Expect it delivered with `if_pc`=0x0C and no fetch at 0x10; after its transfer, `if_valid`=0 and `halted`=1.
  - A later `redirect_valid` is ignored.
- **Fault:** redirect to 0x102 (misaligned), then separately to 0x100 with `MEM_BYTES`=256.
  - Each gives `halted`=1, `fetch_fault`=1 and `if_valid`=0 one edge after the target cycle.
- **Async reset mid-stream:** assert `reset`=0 between edges during RUN.
  - All outputs take reset values immediately; after release, IDLE waits for `start`.
